// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory arbiter: access sizes, response owner,
// and the alignment rule used at grant time.
package mem_arbiter_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // The reserved size encoding is treated like a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data port: store byte enables and replicated write
// data, plus load lane extraction with sign or zero extension.
module mem_lane_align
    import mem_arbiter_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output of an always_comb gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        st_be_o    = 4'b0000;
        st_wdata_o = st_data_i;
        case (st_size_i)
            SZ_B: begin
                st_be_o    = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            SZ_H: begin
                st_be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            SZ_W:    st_be_o = 4'b1111;
            default: st_be_o = 4'b0000;
        endcase
    end

    always_comb begin
        case (ld_off_i)
            2'd0:    byte_sel = ld_word_i[7:0];
            2'd1:    byte_sel = ld_word_i[15:8];
            2'd2:    byte_sel = ld_word_i[23:16];
            default: byte_sel = ld_word_i[31:24];
        endcase
        half_sel = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        case (ld_size_i)
            SZ_B:    ld_data_o = {{24{~ld_unsigned_i & byte_sel[7]}}, byte_sel};
            SZ_H:    ld_data_o = {{16{~ld_unsigned_i & half_sel[15]}}, half_sel};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch, data load/store) in front of a single-port
// synchronous RAM with 1-cycle read latency; data wins unless fetch is starving.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_misalign,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_q, starve_d;
    owner_e           owner_q, owner_d;
    logic [1:0]       ld_size_q, ld_size_d, ld_off_q, ld_off_d;
    logic             ld_uns_q, ld_uns_d, zero_q, zero_d, mis_q, mis_d;
    logic [31:0]      if_hold_q, if_hold_d, d_hold_q, d_hold_d;

    logic        if_gnt_w, d_gnt_w, d_mis, d_access;
    logic [3:0]  st_be;
    logic [31:0] ld_data, d_resp;
    logic        unused_addr_bits;

    // Fetch ignores its low address bits and both ports ignore bits above the RAM.
    assign unused_addr_bits = ^{if_addr[31:ADDR_W], if_addr[1:0], d_addr[31:ADDR_W]};

    assign if_gnt_w = sys_rst_n && if_req && (!d_req || starve_q == CNT_MAX);
    assign d_gnt_w  = sys_rst_n && d_req && !if_gnt_w;
    assign d_mis    = is_misaligned(d_size, d_addr[1:0]);
    assign d_access = d_gnt_w && !d_mis;

    mem_lane_align u_lane (
        .st_size_i     (d_size),
        .st_off_i      (d_addr[1:0]),
        .st_data_i     (d_wdata),
        .st_be_o       (st_be),
        .st_wdata_o    (mem_wdata),
        .ld_size_i     (ld_size_q),
        .ld_off_i      (ld_off_q),
        .ld_unsigned_i (ld_uns_q),
        .ld_word_i     (mem_rdata),
        .ld_data_o     (ld_data)
    );

    assign if_gnt   = if_gnt_w;
    assign d_gnt    = d_gnt_w;
    assign mem_en   = if_gnt_w || d_access;
    assign mem_we   = (d_access && d_we) ? st_be : 4'b0000;
    assign mem_addr = if_gnt_w ? if_addr[ADDR_W-1:2] : d_addr[ADDR_W-1:2];

    assign if_rvalid  = (owner_q == OWN_IF);
    assign d_rvalid   = (owner_q == OWN_D);
    assign d_resp     = zero_q ? 32'h0 : ld_data;
    assign if_rdata   = if_rvalid ? mem_rdata : if_hold_q;
    assign d_rdata    = d_rvalid ? d_resp : d_hold_q;
    assign d_misalign = d_rvalid && mis_q;

    always_comb begin
        starve_d  = starve_q;
        ld_size_d = ld_size_q;
        ld_off_d  = ld_off_q;
        ld_uns_d  = ld_uns_q;
        zero_d    = zero_q;
        mis_d     = mis_q;
        if (if_gnt_w || !if_req) begin
            starve_d = '0;
        end else if (d_gnt_w && starve_q != CNT_MAX) begin
            starve_d = starve_q + 1'b1;
        end
        if (if_gnt_w)     owner_d = OWN_IF;
        else if (d_gnt_w) owner_d = OWN_D;
        else              owner_d = OWN_NONE;
        // Load steering and the zero-response flag are captured at grant time.
        if (d_gnt_w) begin
            ld_size_d = d_size;
            ld_off_d  = d_addr[1:0];
            ld_uns_d  = d_unsigned;
            zero_d    = d_we || d_mis;
            mis_d     = d_mis;
        end
        if_hold_d = if_rvalid ? mem_rdata : if_hold_q;
        d_hold_d  = d_rvalid ? d_resp : d_hold_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            starve_q  <= '0;
            owner_q   <= OWN_NONE;
            ld_size_q <= 2'b00;
            ld_off_q  <= 2'b00;
            ld_uns_q  <= 1'b0;
            zero_q    <= 1'b0;
            mis_q     <= 1'b0;
            if_hold_q <= 32'h0;
            d_hold_q  <= 32'h0;
        end else begin
            starve_q  <= starve_d;
            owner_q   <= owner_d;
            ld_size_q <= ld_size_d;
            ld_off_q  <= ld_off_d;
            ld_uns_q  <= ld_uns_d;
            zero_q    <= zero_d;
            mis_q     <= mis_d;
            if_hold_q <= if_hold_d;
            d_hold_q  <= d_hold_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single data accesses against a RAM model,
// plus hand-written starvation, fetch streaming and reset-abort sequences.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        sys_clk, sys_rst_n;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_unsigned, d_gnt, d_rvalid, d_misalign;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] ram [0:4095];
    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(14), .STARVE_MAX(4)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_unsigned(d_unsigned), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_misalign(d_misalign),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Single-port synchronous RAM, read-before-write, 1-cycle latency.
    always @(posedge sys_clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_en;
        logic [3:0]  exp_we;
        logic [11:0] exp_maddr;
        logic        chk_wdata;
        logic [31:0] exp_wdata;
        logic        exp_mis;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs [18];
    logic [31:0] f_addr [4];
    logic [31:0] f_exp  [4];

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
        ram[0] = 32'h8081_82F3;
        ram[1] = 32'h1122_3344;
        ram[2] = 32'hCAFE_F00D;
        mem_rdata = 32'h0;

        //           we  size   uns addr           wdata          en we    maddr  chkw wdata          mis rdata
        vecs[0]  = '{0, SZ_B,  0, 32'h0000_0003, 32'h0,         1, 4'h0, 12'h0, 0,   32'h0,         0, 32'hFFFF_FF80};
        vecs[1]  = '{0, SZ_B,  1, 32'h0000_0003, 32'h0,         1, 4'h0, 12'h0, 0,   32'h0,         0, 32'h0000_0080};
        vecs[2]  = '{0, SZ_B,  0, 32'h0000_0000, 32'h0,         1, 4'h0, 12'h0, 0,   32'h0,         0, 32'hFFFF_FFF3};
        vecs[3]  = '{0, SZ_B,  1, 32'h0000_0001, 32'h0,         1, 4'h0, 12'h0, 0,   32'h0,         0, 32'h0000_0082};
        vecs[4]  = '{0, SZ_H,  0, 32'h0000_0002, 32'h0,         1, 4'h0, 12'h0, 0,   32'h0,         0, 32'hFFFF_8081};
        vecs[5]  = '{0, SZ_H,  1, 32'h0000_0000, 32'h0,         1, 4'h0, 12'h0, 0,   32'h0,         0, 32'h0000_82F3};
        vecs[6]  = '{0, SZ_W,  0, 32'h0000_0004, 32'h0,         1, 4'h0, 12'h1, 0,   32'h0,         0, 32'h1122_3344};
        vecs[7]  = '{1, SZ_H,  0, 32'h0000_0006, 32'h0000_BEEF, 1, 4'hC, 12'h1, 1,   32'hBEEF_BEEF, 0, 32'h0};
        vecs[8]  = '{0, SZ_W,  0, 32'h0000_0004, 32'h0,         1, 4'h0, 12'h1, 0,   32'h0,         0, 32'hBEEF_3344};
        vecs[9]  = '{1, SZ_B,  0, 32'h0000_0009, 32'h1234_565A, 1, 4'h2, 12'h2, 1,   32'h5A5A_5A5A, 0, 32'h0};
        vecs[10] = '{0, SZ_W,  0, 32'h0000_0008, 32'h0,         1, 4'h0, 12'h2, 0,   32'h0,         0, 32'hCAFE_5A0D};
        vecs[11] = '{1, SZ_W,  0, 32'h0000_0008, 32'h0102_0304, 1, 4'hF, 12'h2, 1,   32'h0102_0304, 0, 32'h0};
        vecs[12] = '{0, SZ_B,  0, 32'h0000_000B, 32'h0,         1, 4'h0, 12'h2, 0,   32'h0,         0, 32'h0000_0001};
        vecs[13] = '{0, SZ_W,  0, 32'h0000_0002, 32'h0,         0, 4'h0, 12'h0, 0,   32'h0,         1, 32'h0};
        vecs[14] = '{0, SZ_H,  0, 32'h0000_0005, 32'h0,         0, 4'h0, 12'h0, 0,   32'h0,         1, 32'h0};
        vecs[15] = '{0, 2'b11, 0, 32'h0000_0000, 32'h0,         0, 4'h0, 12'h0, 0,   32'h0,         1, 32'h0};
        vecs[16] = '{1, SZ_W,  0, 32'h0000_000D, 32'hFFFF_FFFF, 0, 4'h0, 12'h0, 0,   32'h0,         1, 32'h0};
        vecs[17] = '{0, SZ_W,  0, 32'h0001_0004, 32'h0,         1, 4'h0, 12'h1, 0,   32'h0,         0, 32'hBEEF_3344};

        f_addr = '{32'h0, 32'h4, 32'h8, 32'h6};
        f_exp  = '{32'h8081_82F3, 32'hBEEF_3344, 32'h0102_0304, 32'hBEEF_3344};

        // Reset: grants and RAM strobes stay low even with both requests up.
        sys_rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0; d_wdata = 32'hFFFF_FFFF;
        d_size = SZ_W; d_unsigned = 1'b0;
        @(posedge sys_clk); @(posedge sys_clk); #1;
        check("rst_if_gnt", {31'h0, if_gnt}, 32'h0);
        check("rst_d_gnt", {31'h0, d_gnt}, 32'h0);
        check("rst_mem_en", {31'h0, mem_en}, 32'h0);
        check("rst_mem_we", {28'h0, mem_we}, 32'h0);
        check("rst_if_rvalid", {31'h0, if_rvalid}, 32'h0);
        check("rst_d_rvalid", {31'h0, d_rvalid}, 32'h0);
        check("rst_d_misalign", {31'h0, d_misalign}, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        if_req = 1'b0; d_req = 1'b0;
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;

        // Table of back-to-back single data accesses.
        for (int i = 0; i < 18; i++) begin
            d_req = 1'b1; d_we = vecs[i].we; d_size = vecs[i].size;
            d_unsigned = vecs[i].uns; d_addr = vecs[i].addr; d_wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_d_gnt", i), {31'h0, d_gnt}, 32'h1);
            check($sformatf("vec%0d_mem_en", i), {31'h0, mem_en}, {31'h0, vecs[i].exp_en});
            check($sformatf("vec%0d_mem_we", i), {28'h0, mem_we}, {28'h0, vecs[i].exp_we});
            if (vecs[i].exp_en)
                check($sformatf("vec%0d_mem_addr", i), {20'h0, mem_addr}, {20'h0, vecs[i].exp_maddr});
            if (vecs[i].chk_wdata)
                check($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
            @(posedge sys_clk); #1;
            d_req = 1'b0;
            check($sformatf("vec%0d_d_rvalid", i), {31'h0, d_rvalid}, 32'h1);
            check($sformatf("vec%0d_d_misalign", i), {31'h0, d_misalign}, {31'h0, vecs[i].exp_mis});
            check($sformatf("vec%0d_d_rdata", i), d_rdata, vecs[i].exp_rdata);
        end
        #1;
        check("idle_mem_en", {31'h0, mem_en}, 32'h0);
        @(posedge sys_clk); #1;
        check("d_hold_rvalid", {31'h0, d_rvalid}, 32'h0);
        check("d_hold_rdata", d_rdata, 32'hBEEF_3344);

        // Starvation: data held 6 cycles with fetch pending; fetch wins the 5th.
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_size = SZ_W; d_unsigned = 1'b0; d_addr = 32'h4;
        for (int c = 1; c <= 6; c++) begin
            #1;
            check($sformatf("starve%0d_if_gnt", c), {31'h0, if_gnt}, (c == 5) ? 32'h1 : 32'h0);
            check($sformatf("starve%0d_d_gnt", c), {31'h0, d_gnt}, (c == 5) ? 32'h0 : 32'h1);
            @(posedge sys_clk); #1;
            if (c == 5) begin
                check("starve5_if_rvalid", {31'h0, if_rvalid}, 32'h1);
                check("starve5_if_rdata", if_rdata, 32'h8081_82F3);
                check("starve5_d_rvalid", {31'h0, d_rvalid}, 32'h0);
            end else begin
                check($sformatf("starve%0d_d_rvalid", c), {31'h0, d_rvalid}, 32'h1);
                check($sformatf("starve%0d_d_rdata", c), d_rdata, 32'hBEEF_3344);
            end
        end
        if_req = 1'b0; d_req = 1'b0;

        // Back-to-back fetches; low address bits are ignored.
        for (int k = 0; k < 4; k++) begin
            if_req = 1'b1; if_addr = f_addr[k];
            #1;
            check($sformatf("fetch%0d_if_gnt", k), {31'h0, if_gnt}, 32'h1);
            check($sformatf("fetch%0d_mem_we", k), {28'h0, mem_we}, 32'h0);
            @(posedge sys_clk); #1;
            check($sformatf("fetch%0d_if_rvalid", k), {31'h0, if_rvalid}, 32'h1);
            check($sformatf("fetch%0d_if_rdata", k), if_rdata, f_exp[k]);
        end
        if_req = 1'b0;
        @(posedge sys_clk); #1;
        check("fetch_end_if_rvalid", {31'h0, if_rvalid}, 32'h0);
        check("fetch_hold_if_rdata", if_rdata, 32'hBEEF_3344);

        // Reset in the response cycle of a fetch discards the response.
        if_req = 1'b1; if_addr = 32'h4;
        #1;
        check("abort_if_gnt", {31'h0, if_gnt}, 32'h1);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b0; d_req = 1'b1;
        #1;
        check("abort_if_rvalid", {31'h0, if_rvalid}, 32'h0);
        check("abort_if_rdata", if_rdata, 32'h0);
        check("abort_d_rdata", d_rdata, 32'h0);
        check("abort_if_gnt_forced", {31'h0, if_gnt}, 32'h0);
        check("abort_d_gnt_forced", {31'h0, d_gnt}, 32'h0);
        check("abort_mem_en", {31'h0, mem_en}, 32'h0);
        @(posedge sys_clk); @(posedge sys_clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        sys_rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge sys_clk); #1;
            check($sformatf("post%0d_if_rvalid", c), {31'h0, if_rvalid}, 32'h0);
            check($sformatf("post%0d_d_rvalid", c), {31'h0, d_rvalid}, 32'h0);
            check($sformatf("post%0d_d_misalign", c), {31'h0, d_misalign}, 32'h0);
            check($sformatf("post%0d_if_rdata", c), if_rdata, 32'h0);
            check($sformatf("post%0d_d_rdata", c), d_rdata, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, byte-address width of the shared RAM (16 KiB).
REQ-002 Parameter STARVE_MAX, default 4, consecutive data grants allowed while fetch waits.
REQ-003 sys_clk  in  1  single clock; all state on rising edge.
REQ-004 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-005 if_req  in  1 / if_addr  in  32 -- fetch read request and byte address.
REQ-006 if_gnt  out  1 / if_rvalid  out  1 / if_rdata  out  32 -- fetch grant, response valid, instruction word.
REQ-007 d_req  in  1 / d_we  in  1 / d_addr  in  32 / d_wdata  in  32 -- data request, write enable, byte address, store data.
REQ-008 d_size  in  2 (00 byte, 01 half, 10 word, 11 illegal) / d_unsigned  in  1 (zero-extend loads).
REQ-009 d_gnt  out  1 / d_rvalid  out  1 / d_rdata  out  32 / d_misalign  out  1 -- data grant, response valid, extended load data, fault flag.
REQ-010 mem_en  out  1 / mem_we  out  4 / mem_addr  out  ADDR_W-2 / mem_wdata  out  32 / mem_rdata  in  32 -- single-port synchronous RAM with 1-cycle read latency.

Function
REQ-011 Requesters hold req and addr stable until gnt; gnt is combinational in the request cycle; at most one of if_gnt, d_gnt per cycle.
REQ-012 Priority: data over fetch, except when the starvation counter equals STARVE_MAX with if_req high, in which case fetch wins that cycle.
REQ-013 Starvation counter increments on each d_gnt while if_req is high, clears on if_gnt or if_req low, saturates at STARVE_MAX.
REQ-014 Granted access drives mem_en=1, mem_addr=addr[ADDR_W-1:2] in the grant cycle; address bits above ADDR_W ignored.
REQ-015 Response: rvalid of the granted port pulses exactly one cycle after grant; back-to-back grants give back-to-back responses.
REQ-016 Store byte: mem_we=4'b0001<<addr[1:0], mem_wdata = wdata[7:0] replicated 4x.
REQ-017 Store half: mem_we=addr[1]?4'b1100:4'b0011, mem_wdata = wdata[15:0] replicated 2x; store word: mem_we=4'b1111.
REQ-018 Loads: register size, unsigned, addr[1:0] at grant; next cycle select byte/half lane from mem_rdata, sign- or zero-extend to 32 bits.
REQ-019 Store response: d_rvalid pulses next cycle with d_rdata=0.
REQ-020 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or d_size=11: d_gnt asserted, mem_en=0, mem_we=0; next cycle d_rvalid=1, d_misalign=1, d_rdata=0.
REQ-021 Fetch always word read; if_addr[1:0]!=0 ignored (word-aligned by fetch unit); if_rdata = mem_rdata unmodified.
REQ-022 Response owner register: NONE, IF, DATA; set at grant, NONE when no grant; rdata outputs hold last value when rvalid low.
REQ-023 No requests: mem_en=0, mem_we=0, counter unchanged.

Reset
REQ-024 Asynchronous assertion clears owner to NONE, counter to 0, latched size/offset to 0; if_rvalid, d_rvalid, d_misalign, if_rdata, d_rdata = 0.
REQ-025 Grant outputs and mem_en/mem_we forced 0 while sys_rst_n low.
REQ-026 Reset mid-access discards the outstanding response; no rvalid after deassertion without a new grant.

Structure
REQ-027 Shared package holds d_size encodings (SZ_B, SZ_H, SZ_W), owner enum (OWN_NONE, OWN_IF, OWN_D).
REQ-028 One sub-module: mem_lane_align (combinational store lane/byte-enable generation and load extract/extend).

Verification
REQ-029 RAM word 0x0 = 0x8081_82F3; d load byte signed addr 0x3 -> d_rvalid next cycle, d_rdata=0xFFFF_FF80; unsigned -> 0x0000_0080.
REQ-030 d store half 0xBEEF at addr 0x6 -> mem_we=4'b1100, mem_wdata=0xBEEF_BEEF; reading word 0x4 shows 0xBEEFxxxx.
REQ-031 if_req, d_req both high, same cycle -> d_gnt=1, if_gnt=0; d_req held 5 cycles -> 5th cycle if_gnt=1, d_gnt=0.
REQ-032 d load word addr 0x2 -> mem_en=0, next cycle d_rvalid=1, d_misalign=1, d_rdata=0.
REQ-033 Alternating fetch 0x0, 0x4, 0x8 each cycle -> if_rvalid high 3 consecutive cycles, data matches RAM words in order.
REQ-034 sys_rst_n low in cycle after fetch grant -> if_rvalid stays 0; outputs all 0 until new grant.
